// File: rtl/target_scheduler.sv
// Whack-a-mole style target scheduler: lights one of eight targets at pseudo-random,
// scores rising-edge hits on the lit target and runs a seconds countdown for the game.
module target_scheduler #(
  parameter int          GAME_SECONDS  = 30,
  parameter int          WINDOW_CYCLES = 50_000_000,
  parameter int          GAP_CYCLES    = 10_000_000,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic       clkIn,
  input  logic       reset,
  input  logic       start,
  input  logic       sec_tick,
  input  logic [7:0] buttons,
  output logic [7:0] target_led,
  output logic       player_scored,
  output logic       timer_expired,
  output logic [5:0] seconds_left,
  output logic       busy
);

  localparam int MAX_CYCLES = (WINDOW_CYCLES > GAP_CYCLES) ? WINDOW_CYCLES : GAP_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] WIN_LAST  = CNT_W'(WINDOW_CYCLES - 1);
  localparam logic [5:0]       GAME_SECS = 6'(GAME_SECONDS);
  localparam logic [15:0]      LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    IDLE,
    GAP,
    SHOW,
    DONE
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [15:0]      lfsr;
  logic [7:0]       btn_q;
  logic [2:0]       prev_idx, prev_idx_n;
  logic [2:0]       pick;
  logic [7:0]       led_n;
  logic             scored_n;
  logic             expired_n;
  logic [5:0]       secs_n;
  logic             hit;
  logic             final_tick;

  // prev_idx doubles as the lit index while in SHOW, since it is updated on GAP->SHOW
  assign pick       = (lfsr[2:0] == prev_idx) ? (lfsr[2:0] + 3'd1) : lfsr[2:0];
  assign hit        = buttons[prev_idx] & ~btn_q[prev_idx];
  assign final_tick = sec_tick && (seconds_left == 6'd1);

  always_ff @(posedge clkIn or posedge reset) begin
    if (reset) begin
      lfsr  <= LFSR_SEED;
      btn_q <= 8'h00;
    end else begin
      lfsr  <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
      btn_q <= buttons;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    prev_idx_n = prev_idx;
    led_n      = target_led;
    scored_n   = 1'b0;
    expired_n  = 1'b0;
    secs_n     = seconds_left;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n = GAP;
          secs_n  = GAME_SECS;
          cnt_n   = '0;
          led_n   = 8'h00;
        end
      end

      GAP, SHOW: begin
        // The final tick wins over any phase event, including a same-cycle hit
        if (final_tick) begin
          state_n   = DONE;
          secs_n    = 6'd0;
          expired_n = 1'b1;
          led_n     = 8'h00;
          cnt_n     = '0;
        end else begin
          if (sec_tick && (seconds_left != 6'd0)) begin
            secs_n = seconds_left - 6'd1;
          end
          if (state == GAP) begin
            if (cnt == GAP_LAST) begin
              state_n    = SHOW;
              cnt_n      = '0;
              prev_idx_n = pick;
              led_n      = 8'd1 << pick;
            end else begin
              cnt_n = cnt + 1'b1;
            end
          end else if (hit) begin
            state_n  = GAP;
            cnt_n    = '0;
            led_n    = 8'h00;
            scored_n = 1'b1;
          end else if (cnt == WIN_LAST) begin
            state_n = GAP;
            cnt_n   = '0;
            led_n   = 8'h00;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clkIn or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      prev_idx      <= 3'd0;
      target_led    <= 8'h00;
      player_scored <= 1'b0;
      timer_expired <= 1'b0;
      seconds_left  <= 6'd0;
      busy          <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      prev_idx      <= prev_idx_n;
      target_led    <= led_n;
      player_scored <= scored_n;
      timer_expired <= expired_n;
      seconds_left  <= secs_n;
      busy          <= (state_n == GAP) || (state_n == SHOW);
    end
  end

endmodule

// File: doc/target_scheduler.md
TARGET_SCHEDULER -- requirements
Module: target_scheduler

Interface
REQ-001 SHALL have parameter GAME_SECONDS, default 30, game length in seconds (legal range 1..63).
REQ-002 SHALL have parameter WINDOW_CYCLES, default 50_000_000, number of clkIn cycles a target stays lit.
REQ-003 SHALL have parameter GAP_CYCLES, default 10_000_000, number of dark clkIn cycles between targets.
REQ-004 SHALL have parameter LFSR_SEED, default 16'hACE1, LFSR reset value (nonzero).
REQ-005 SHALL have port clkIn, input, 1 bit, 100 MHz system clock.
REQ-006 SHALL have port reset, input, 1 bit, asynchronous, active-high.
REQ-007 SHALL have port start, input, 1 bit, one-cycle start/replay strobe, synchronous to clkIn.
REQ-008 SHALL have port sec_tick, input, 1 bit, one-cycle 1 Hz strobe, synchronous to clkIn.
REQ-009 SHALL have port buttons, input, 8 bits, debounced and synchronized player buttons, active-high.
REQ-010 SHALL have port target_led, output, 8 bits, one-hot lit target, or all zero.
REQ-011 SHALL have port player_scored, output, 1 bit, one-cycle hit pulse.
REQ-012 SHALL have port timer_expired, output, 1 bit, one-cycle end-of-game pulse.
REQ-013 SHALL have port seconds_left, output, 6 bits, remaining game time.
REQ-014 SHALL have port busy, output, 1 bit, high while a game is in progress.

Function
REQ-015 SHALL implement states IDLE, GAP, SHOW and DONE; busy=1 exactly in GAP and SHOW; all outputs SHALL be registered.
REQ-016 SHALL, in IDLE or DONE on start=1, go to GAP, load seconds_left=GAME_SECONDS and clear the phase counter.
REQ-017 SHALL ignore start while in GAP or SHOW.
REQ-018 SHALL, in GAP, hold target_led=0 and go to SHOW after exactly GAP_CYCLES cycles in GAP.
REQ-019 SHALL advance a 16-bit Galois LFSR (taps x^16+x^14+x^13+x^11+1) every clkIn cycle.
REQ-020 SHALL, on GAP->SHOW, take idx=lfsr[2:0]; if idx equals the previous target index, SHALL use (idx+1) mod 8 instead.
REQ-021 SHALL, in SHOW, drive target_led=1<<idx.
REQ-022 SHALL define hit as buttons[idx]=1 while the previous-cycle registered copy of buttons[idx] is 0 (rising edge).
REQ-023 SHALL, on a hit in SHOW, assert player_scored for exactly the next cycle, clear target_led, and go to GAP.
REQ-024 SHALL ignore rising edges on non-target buttons, and buttons held high across the GAP->SHOW transition.
REQ-025 SHALL, when SHOW lasts WINDOW_CYCLES cycles with no hit, go to GAP without a score pulse.
REQ-026 SHALL, on sec_tick in GAP or SHOW, decrement seconds_left by 1, saturating at 0.
REQ-027 SHALL, on sec_tick while seconds_left==1, set seconds_left=0, go to DONE, pulse timer_expired for one cycle and clear target_led.
REQ-028 SHALL, when a hit and the final sec_tick occur in the same cycle, let the tick take priority: DONE, timer_expired=1, player_scored=0.
REQ-029 SHALL ignore sec_tick in IDLE and DONE; seconds_left SHALL hold its value in DONE.
REQ-030 SHALL never assert player_scored and timer_expired in the same cycle, nor either output outside GAP/SHOW exits.

Reset
REQ-031 SHALL, on reset, asynchronously force state=IDLE, target_led=0, player_scored=0, timer_expired=0, seconds_left=0, busy=0, counters=0, lfsr=LFSR_SEED, previous index=0 and the buttons copy=0.
REQ-032 SHALL, on reset asserted mid-game, abort immediately with no pulse, and require start to resume.

Verification (GAME_SECONDS=3, WINDOW_CYCLES=20, GAP_CYCLES=5)
REQ-033 Bench SHALL check: reset, then start -> busy=1, seconds_left=3, target_led=0 for 5 cycles, then a one-hot target_led.
REQ-034 Bench SHALL check: rising edge on the lit button in SHOW -> player_scored high exactly 1 cycle, target_led=0, next target appears 5 cycles later and differs from the previous one.
REQ-035 Bench SHALL check: no press for 20 SHOW cycles -> return to GAP, player_scored stays 0; a wrong-button press or a held button -> no score.
REQ-036 Bench SHALL check: 3 sec_ticks -> seconds_left goes 2,1,0, then DONE, timer_expired 1-cycle pulse, busy=0; a hit coincident with the 3rd tick -> no player_scored.
REQ-037 Bench SHALL check: start in DONE -> seconds_left=3 and a new game; start mid-game -> ignored.
REQ-038 Bench SHALL check: reset asserted in SHOW -> all outputs 0 immediately, state IDLE, no pulses.
